pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised fetch-address generator for the 5-stage pipeline, replacing the fixed 32-bit program counter. It holds the IF-stage PC and a fetch-valid flag, and selects the next PC from five sources in priority order:

- exception vector
- resolved redirect (branch/jump from EX)
- optional return-address-stack prediction
- stall hold
- sequential increment

It also adds a halt state, and a one-cycle initialisation state that directly follows reset.

## Interface
- `WIDTH`, default 32: PC width in bits.
- `RESET_VECTOR`, default 0: PC value while in reset and in INIT.
- `EXC_VECTOR`, default 32'h0000_0180: exception handler address.
- `STEP`, default 4: sequential increment.
- `RAS_DEPTH`, default 4: return-address-stack entries (≥2).

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: **asynchronous, active-high** reset.
- `stall`  in  1: hold the PC (IF/ID load-use stall).
- `redirect_valid`  in  1: taken branch/jump resolved in EX.
- `redirect_target`  in  WIDTH: target for `redirect_valid`.
- `exc_valid`  in  1: exception taken; vector to `EXC_VECTOR`.
- `halt`  in  1: enter HALT (break/syscall-halt decoded in ID).
- `ras_push`  in  1: ID has decoded a call (jal/jalr).
- `ras_push_addr`  in  WIDTH: return address to push.
- `ras_pop`  in  1: ID has decoded a `jr $ra`.
- `pc`  out  WIDTH: current fetch address.
- `pc_plus`  out  WIDTH: `pc + STEP`, computed combinationally.
- `fetch_valid`  out  1: `pc` is a real fetch.
- `ras_hit`  out  1: `pc` came from a RAS pop.
- `ras_count`  out  $clog2(RAS_DEPTH+1): RAS occupancy.

## Operation
- **States:** INIT, RUN, HALT.
- **Reset (async):**
  - State goes to INIT.
  - `pc` = RESET_VECTOR.
  - `fetch_valid`, `ras_hit` and `ras_count` = 0.
  - RAS contents are don't-care.
- **INIT:**
  - The first edge with `rst` low moves the state to RUN.
  - `fetch_valid` goes to 1.
  - `pc` is unchanged.
  - All other inputs are ignored.
- **RUN, next-PC priority (highest first):**
  - `exc_valid`: `pc` ← EXC_VECTOR; RAS is flushed (count = 0).
  - `redirect_valid`: `pc` ← `redirect_target` with bits [1:0] forced to 0.
  - Valid RAS pop: `pc` ← top of stack; `ras_hit` ← 1.
  - `stall`: `pc` holds.
  - Otherwise: `pc` ← `pc + STEP`, modulo 2^WIDTH, so all-ones minus 3 wraps to 0.
- `exc_valid` and `redirect_valid` override both `stall` and `halt`.
- **`halt` in RUN**, when `exc_valid` and `redirect_valid` are both low:
  - State goes to HALT.
  - `fetch_valid` ← 0.
  - `pc` holds.
- **HALT:**
  - `pc` is frozen and `fetch_valid` = 0.
  - `exc_valid` or `redirect_valid` loads the new PC, returns the state to RUN and sets `fetch_valid` = 1.
  - `stall`, `halt` and RAS ops are ignored.
- **RAS ops:**
  - They take effect only in RUN, with `stall`, `exc_valid`, `redirect_valid` and `halt` all low. The instruction in ID is squashed or stalled otherwise.
  - A pop is valid only when `ras_count` > 0.
  - Pop on empty is ignored: sequential fetch, `ras_hit` = 0.
  - Push when full overwrites the oldest entry (circular); `ras_count` saturates at RAS_DEPTH.
  - Simultaneous push and pop: the pop target is the old top, and the pushed value replaces it. `ras_count` is unchanged. Pop on empty plus push is a plain push.
- `ras_hit` is 1 only in the cycle after a valid pop; it is 0 otherwise.

## Timing
- All outputs are registered except `pc_plus`, which is combinational from `pc`.
- Latency is 1 cycle. Control sampled at edge *n* determines `pc` after edge *n*.
- A redirect presented in cycle *n* is fetched in cycle *n+1*. There are no bubbles beyond those the pipeline inserts.
- Assertion of `rst` at any cycle takes effect immediately. Any operation in flight (including a RAS update) is discarded.
- Deassertion of `rst` is followed by exactly one INIT cycle (`fetch_valid` = 0) before RUN.

## Configuration
- `PC_RAS_EN`
  - **Defined:** the return-address stack is built as described above.
  - **Undefined:**
    - No RAS storage is built.
    - `ras_push` and `ras_pop` are ignored.
    - `ras_hit` and `ras_count` are tied to 0.
    - `jr $ra` falls back to the EX redirect.
    - All other behaviour is identical.

## Test plan
- **Reset/INIT:**
  - Stimulus: assert `rst` mid-run at `pc` = 0x40, release, 3 idle clocks.
  - Response: `pc` = 0 and `fetch_valid` = 0 immediately (async) and through the INIT edge; then `fetch_valid` = 1, `pc` = 0 → 4 → 8.
- **Priority:**
  - Stimulus: one cycle with `exc_valid`, `redirect_valid` (target 0x1003), `stall` and `ras_pop` all high.
  - Response: next `pc` = 0x180, `ras_count` = 0.
  - Repeat without `exc_valid`: next `pc` = 0x1000.
- **Stall/wrap:**
  - Stimulus: `pc` = 0xFFFF_FFF8, stall 2 cycles, release.
  - Response: `pc` holds at 0xFFFF_FFF8 for 2 cycles, then 0xFFFF_FFFC, then 0x0.
- **HALT:**
  - Stimulus: pulse `halt`, then idle 3 cycles.
  - Response: `fetch_valid` = 0, `pc` frozen.
  - Stimulus: `redirect_valid` to 0x200.
  - Response: `pc` = 0x200, `fetch_valid` = 1.
- **RAS (PC_RAS_EN, depth 4):**
  - Stimulus: push 0x10, 0x20, 0x30, 0x40, 0x50 (overflow), then 5 pops.
  - Response: targets 0x50, 0x40, 0x30, 0x20 with `ras_hit` = 1; the 5th pop is sequential with `ras_hit` = 0; `ras_count` 4 → 0.
- **RAS gating:**
  - Stimulus: pop while `stall` = 1.
  - Response: no effect.
  - Stimulus: push and pop together at count 2, top = 0x30, push 0x70.
  - Response: `pc` = 0x30, count stays 2, new top = 0x70.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: IF-stage fetch-address generator with INIT/RUN/HALT control and an
// optional return-address stack, built only when PC_RAS_EN is defined.
// Next-PC priority: exception, redirect, halt, RAS pop, stall, sequential.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [WIDTH-1:0]               redirect_target,
  input  logic                           exc_valid,
  input  logic                           halt,
  input  logic                           ras_push,
  input  logic [WIDTH-1:0]               ras_push_addr,
  input  logic                           ras_pop,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus,
  output logic                           fetch_valid,
  output logic                           ras_hit,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             fv_n;
  logic             hit_n;
  logic             ras_flush_c;
  logic             ras_wr_c;
  logic             ras_rd_c;
  logic             ras_nonempty_c;
  logic [WIDTH-1:0] ras_top_c;
  logic [WIDTH-1:0] redirect_aligned_c;
  logic             redirect_low_unused_c;

  assign pc_plus               = pc + WIDTH'(STEP);
  assign redirect_aligned_c    = {redirect_target[WIDTH-1:2], 2'b00};
  assign redirect_low_unused_c = ^redirect_target[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, next-PC and RAS control decode
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    fv_n        = fetch_valid;
    hit_n       = 1'b0;
    ras_flush_c = 1'b0;
    ras_wr_c    = 1'b0;
    ras_rd_c    = 1'b0;
    unique case (state)
      ST_INIT: begin
        state_n = ST_RUN;
        fv_n    = 1'b1;
      end
      ST_RUN: begin
        if (exc_valid) begin
          pc_n        = EXC_VECTOR;
          ras_flush_c = 1'b1;
        end else if (redirect_valid) begin
          pc_n = redirect_aligned_c;
        end else if (halt) begin
          state_n = ST_HALT;
          fv_n    = 1'b0;
        end else if (!stall) begin
          ras_wr_c = ras_push;
          if (ras_pop && ras_nonempty_c) begin
            pc_n     = ras_top_c;
            hit_n    = 1'b1;
            ras_rd_c = 1'b1;
          end else begin
            pc_n = pc_plus;
          end
        end
      end
      ST_HALT: begin
        if (exc_valid) begin
          pc_n        = EXC_VECTOR;
          ras_flush_c = 1'b1;
          state_n     = ST_RUN;
          fv_n        = 1'b1;
        end else if (redirect_valid) begin
          pc_n    = redirect_aligned_c;
          state_n = ST_RUN;
          fv_n    = 1'b1;
        end
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  // Registered fetch outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      ras_hit     <= 1'b0;
    end else begin
      pc          <= pc_n;
      fetch_valid <= fv_n;
      ras_hit     <= hit_n;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW-1:0]    ras_ptr_inc_c;
  logic [PW-1:0]    ras_ptr_dec_c;

  // Circular stack: ras_ptr indexes the top; a push when full reuses the oldest slot
  assign ras_ptr_inc_c  = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PW'(1);
  assign ras_ptr_dec_c  = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - PW'(1);
  assign ras_top_c      = ras_mem[ras_ptr];
  assign ras_nonempty_c = (ras_count != '0);

  // Stack pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_flush_c) begin
      ras_count <= '0;
    end else if (ras_wr_c && ras_rd_c) begin
      ras_count <= ras_count;
    end else if (ras_wr_c) begin
      ras_ptr <= ras_ptr_inc_c;
      if (ras_count != CW'(RAS_DEPTH)) begin
        ras_count <= ras_count + CW'(1);
      end
    end else if (ras_rd_c) begin
      ras_ptr   <= ras_ptr_dec_c;
      ras_count <= ras_count - CW'(1);
    end
  end

  // Stack storage; push with pop replaces the current top in place
  always_ff @(posedge clk) begin
    if (ras_wr_c) begin
      ras_mem[ras_rd_c ? ras_ptr : ras_ptr_inc_c] <= ras_push_addr;
    end
  end
`else
  logic ras_ctl_unused_c;

  // No stack: pops never hit, occupancy is always zero
  assign ras_nonempty_c   = 1'b0;
  assign ras_top_c        = '0;
  assign ras_count        = '0;
  assign ras_ctl_unused_c = ^{ras_flush_c, ras_wr_c, ras_rd_c, ras_push_addr};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver advances a queue-based reference
// model and pushes the expected state; the monitor pops and compares each cycle.
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int RAS_D = 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        halt;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_pop;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        fetch_valid;
  logic        ras_hit;
  logic [2:0]  ras_count;

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h180), .STEP(4), .RAS_DEPTH(RAS_D)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .halt(halt),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .ras_hit(ras_hit), .ras_count(ras_count)
  );

  typedef struct {
    logic [31:0] pc;
    bit          fv;
    bit          hit;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: mode 0 = initialising, 1 = running, 2 = halted
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;
  bit          m_fv   = 1'b0;
  bit          m_hit  = 1'b0;
  logic [31:0] m_ras[$];
  bit          prev_rst = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, s, rv, input logic [31:0] rt,
                            input bit e, h, pu, input logic [31:0] pa, input bit po);
    m_hit = 1'b0;
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_fv = 1'b0; m_ras.delete();
    end else if (m_mode == 0) begin
      m_mode = 1; m_fv = 1'b1;
    end else if (e) begin
      m_pc = 32'h180; m_ras.delete(); m_mode = 1; m_fv = 1'b1;
    end else if (rv) begin
      m_pc = rt & 32'hFFFF_FFFC; m_mode = 1; m_fv = 1'b1;
    end else if (m_mode == 2) begin
      // halted: everything else ignored
    end else if (h) begin
      m_mode = 2; m_fv = 1'b0;
    end else if (!s) begin
      if (RAS_ON && po && m_ras.size() > 0) begin
        m_pc  = m_ras.pop_back();
        m_hit = 1'b1;
        if (pu) m_ras.push_back(pa);
      end else begin
        m_pc = m_pc + 32'd4;
        if (RAS_ON && pu) begin
          if (m_ras.size() == RAS_D) void'(m_ras.pop_front());
          m_ras.push_back(pa);
        end
      end
    end
  endtask

  // One clock of stimulus; inputs change on the falling edge
  task automatic cyc(input bit r, s, rv, input logic [31:0] rt,
                     input bit e, h, pu, input logic [31:0] pa, input bit po);
    exp_t x;
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
    exc_valid = e; halt = h; ras_push = pu; ras_push_addr = pa; ras_pop = po;
    if (r && !prev_rst) begin
      #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_fv", 32'(fetch_valid), 32'h0);
      check("async_rst_cnt", 32'(ras_count), 32'h0);
    end
    prev_rst = r;
    model_step(r, s, rv, rt, e, h, pu, pa, po);
    x.pc = m_pc; x.fv = m_fv; x.hit = m_hit; x.cnt = m_ras.size();
    exp_q.push_back(x);
  endtask

  task automatic idle();            cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0); endtask
  task automatic redir(input logic [31:0] t); cyc(0, 0, 1, t, 0, 0, 0, 32'h0, 0); endtask
  task automatic push(input logic [31:0] a);  cyc(0, 0, 0, 32'h0, 0, 0, 1, a, 0); endtask
  task automatic pop();             cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1); endtask

  // Monitor: every rising edge after stimulus starts yields one expected state
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus", pc_plus, e.pc + 32'd4);
        check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        check("ras_hit", 32'(ras_hit), 32'(e.hit));
        check("ras_count", 32'(ras_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    exc_valid = 1'b0; halt = 1'b0; ras_push = 1'b0; ras_push_addr = 32'h0; ras_pop = 1'b0;

    // Reset, INIT, then mid-run reset at pc 0x40
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    repeat (3) idle();
    redir(32'h40);
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    repeat (3) idle();

    // Priority: exception beats redirect, stall and pop; then redirect alone
    push(32'h10); push(32'h20);
    cyc(0, 1, 1, 32'h1003, 1, 0, 0, 32'h0, 1);
    push(32'h10); push(32'h20);
    cyc(0, 1, 1, 32'h1003, 0, 0, 0, 32'h0, 1);

    // Stall and wrap-around
    redir(32'hFFFF_FFF8);
    cyc(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    idle(); idle();

    // Halt and resume by redirect; halt with stall/pop is ignored while halted
    cyc(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
    repeat (3) idle();
    cyc(0, 1, 0, 32'h0, 0, 1, 1, 32'h99, 1);
    redir(32'h200);
    idle();

    // RAS overflow then drain
    cyc(0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0);
    push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
    repeat (5) pop();

    // RAS gating and simultaneous push/pop
    push(32'h20); push(32'h30);
    cyc(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 0, 0, 1, 32'h70, 1);
    pop();
    pop();
    cyc(0, 0, 0, 32'h0, 0, 0, 1, 32'h88, 1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 120) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0, $urandom,
          ($urandom % 30) == 0, ($urandom % 30) == 0, ($urandom % 3) == 0,
          $urandom & 32'hFFFF_FFFC, ($urandom % 3) == 0);
    end
    idle();

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
